// File: rtl/mgemmv_csa_pkg.sv
// Shared definitions for the MGEMMV CSA -> CPA resolution path.
// Holds the default operand/accumulator widths, the split-point helpers
// for the two-stage carry-propagate adder, and the P1 payload type.
package mgemmv_csa_pkg;

    localparam int S_W_DEF   = 12;
    localparam int C_W_DEF   = 12;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

    // Resolved operand width: one bit more than the wider CSA vector.
    function automatic int calc_p(input int s_w, input int c_w);
        return ((s_w > c_w) ? s_w : c_w) + 1;
    endfunction

    // Low half gets the extra bit when P is odd.
    function automatic int calc_lo(input int p);
        return (p + 1) / 2;
    endfunction

    function automatic int calc_hi(input int p);
        return p - calc_lo(p);
    endfunction

    localparam int P_DEF  = calc_p(S_W_DEF, C_W_DEF);
    localparam int LO_DEF = calc_lo(P_DEF);
    localparam int HI_DEF = calc_hi(P_DEF);

    // State carried from the low-half add to the high-half add.
    // Sized from the default operand widths; the adder's S_W/C_W must
    // match them.
    typedef struct packed {
        logic [LO_DEF-1:0] lo_sum;
        logic              c1;
        logic [HI_DEF-1:0] sum_hi;
        logic [HI_DEF-1:0] carry_hi;
        logic              last;
    } p1_t;

endpackage

// File: rtl/csa_cpa_split2.sv
// Two-stage split carry-propagate adder.
// P1 adds the low halves of the zero-extended sum/carry vectors and keeps
// the carry-out; P2 adds the high halves plus that carry and emits the
// full P-bit binary value. Both stages hold when en is low.
module csa_cpa_split2
    import mgemmv_csa_pkg::*;
#(
    parameter int S_W = S_W_DEF,
    parameter int C_W = C_W_DEF,
    localparam int P  = calc_p(S_W, C_W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           in_valid,
    input  logic [S_W-1:0] in_sum,
    input  logic [C_W-1:0] in_carry,
    input  logic           in_last,
    output logic           p2_valid,
    output logic [P-1:0]   p2_prod,
    output logic           p2_last
);

    localparam int LO = calc_lo(P);
    localparam int HI = calc_hi(P);

    logic [P-1:0]  sum_ext;
    logic [P-1:0]  carry_ext;
    logic [LO:0]   lo_full;
    p1_t           p1_d;
    p1_t           p1_q;
    logic          p1_valid;
    logic [HI-1:0] hi_res;

    // Zero-extend both operands and form the low-half partial sum.
    always_comb begin
        sum_ext       = {{(P - S_W){1'b0}}, in_sum};
        carry_ext     = {{(P - C_W){1'b0}}, in_carry};
        lo_full       = {1'b0, sum_ext[LO-1:0]} + {1'b0, carry_ext[LO-1:0]};
        p1_d          = '0;
        p1_d.lo_sum   = lo_full[LO-1:0];
        p1_d.c1       = lo_full[LO];
        p1_d.sum_hi   = sum_ext[P-1:LO];
        p1_d.carry_hi = carry_ext[P-1:LO];
        p1_d.last     = in_last;
    end

    // P1 register: captures an accepted beat's low-half result.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_q     <= '0;
        end else if (en) begin
            p1_valid <= in_valid;
            p1_q     <= p1_d;
        end
    end

    // High half plus the low-half carry; cannot overflow HI bits because
    // the operands were zero-extended by one bit.
    always_comb begin
        hi_res = p1_q.sum_hi + p1_q.carry_hi + HI'(p1_q.c1);
    end

    // P2 register: the resolved binary value of the beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            p2_valid <= 1'b0;
            p2_prod  <= '0;
            p2_last  <= 1'b0;
        end else if (en) begin
            p2_valid <= p1_valid;
            p2_prod  <= {hi_res, p1_q.lo_sum};
            p2_last  <= p1_q.last;
        end
    end

endmodule

// File: rtl/csa_cpa_accum.sv
// CSA (sum, carry) resolver and per-vector accumulator.
// Each accepted beat is resolved to binary by csa_cpa_split2, then summed
// into an ACC_W accumulator until a beat flagged in_last arrives, at which
// point one result (value, beat count, overflow flag) is presented.
//
// Handshake: a transfer happens on a port in any cycle where its valid and
// ready are both high. A presented result is held stable until taken.
// While a result is held (out_valid & ~out_ready) the whole pipeline
// freezes and in_ready is low, so results always leave in order.
//
// Build option: define CSA_CPA_SAT_EN to clamp the accumulator to all-ones
// when it carries out of ACC_W; otherwise it wraps. out_ovf reports the
// carry-out either way.
module csa_cpa_accum
    import mgemmv_csa_pkg::*;
#(
    parameter int S_W   = S_W_DEF,
    parameter int C_W   = C_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [S_W-1:0]   in_sum,
    input  logic [C_W-1:0]   in_carry,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    localparam int P = calc_p(S_W, C_W);

    logic             stall;
    logic             pipe_en;
    logic             acc_en;
    logic             p2_valid;
    logic [P-1:0]     p2_prod;
    logic             p2_last;

    logic [ACC_W-1:0] acc;
    logic             first;
    logic             sticky;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W:0]   acc_base;
    logic [ACC_W:0]   acc_next;
    logic [ACC_W-1:0] acc_res;
    logic             acc_carry;
    logic [CNT_W-1:0] cnt_inc;

    assign stall    = out_valid & ~out_ready;
    assign pipe_en  = ~stall;
    assign in_ready = pipe_en;
    assign acc_en   = p2_valid & pipe_en;

    csa_cpa_split2 #(
        .S_W (S_W),
        .C_W (C_W)
    ) u_split2 (
        .clk      (clk),
        .rst      (rst),
        .en       (pipe_en),
        .in_valid (in_valid),
        .in_sum   (in_sum),
        .in_carry (in_carry),
        .in_last  (in_last),
        .p2_valid (p2_valid),
        .p2_prod  (p2_prod),
        .p2_last  (p2_last)
    );

    // Next accumulator value, its carry-out and the saturating beat count.
    always_comb begin
        acc_base  = first ? '0 : {1'b0, acc};
        acc_next  = acc_base + {{(ACC_W + 1 - P){1'b0}}, p2_prod};
        acc_carry = acc_next[ACC_W];
`ifdef CSA_CPA_SAT_EN
        acc_res   = acc_carry ? '1 : acc_next[ACC_W-1:0];
`else
        acc_res   = acc_next[ACC_W-1:0];
`endif
        cnt_inc   = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    // Per-vector accumulation state; restarts after every last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            first  <= 1'b1;
            sticky <= 1'b0;
            cnt    <= '0;
        end else if (acc_en) begin
            acc <= acc_res;
            if (p2_last) begin
                first  <= 1'b1;
                sticky <= 1'b0;
                cnt    <= '0;
            end else begin
                first  <= 1'b0;
                sticky <= sticky | acc_carry;
                cnt    <= cnt_inc;
            end
        end
    end

    // Result register: loads on a last beat, otherwise drops when taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
        end else if (acc_en && p2_last) begin
            out_valid <= 1'b1;
            out_acc   <= acc_res;
            out_cnt   <= cnt_inc;
            out_ovf   <= sticky | acc_carry;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csa_cpa_accum.sv
// Directed bench for csa_cpa_accum, built with ACC_W=16 so the overflow
// vector wraps (or clamps with CSA_CPA_SAT_EN) at a small value.
module tb_csa_cpa_accum;

    localparam int S_W   = 12;
    localparam int C_W   = 12;
    localparam int ACC_W = 16;
    localparam int CNT_W = 8;
    localparam int EW    = 1 + CNT_W + ACC_W;

`ifdef CSA_CPA_SAT_EN
    localparam int OVF_ACC = 32'hFFFF;
`else
    localparam int OVF_ACC = 8174;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [S_W-1:0]   in_sum;
    logic [C_W-1:0]   in_carry;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    bit toggling;

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csa_cpa_accum #(
        .S_W   (S_W),
        .C_W   (C_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next n rising edges (the drive phase).
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int acc, input int cnt, input bit ovf);
        exp_q.push_back({ovf, CNT_W'(cnt), ACC_W'(acc)});
    endtask

    // Offer one beat and return just after the edge that accepts it.
    task automatic send_beat(input int s, input int c, input bit last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_sum   = S_W'(s);
        in_carry = C_W'(c);
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            tick(1);
            k++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        tick(1);
    endtask

    // Scoreboard: every result taken by the sink is compared in order.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_acc", 32'(out_acc), 32'(mon_e[ACC_W-1:0]));
                check("out_cnt", 32'(out_cnt), 32'(mon_e[ACC_W +: CNT_W]));
                check("out_ovf", 32'(out_ovf), 32'(mon_e[EW-1]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        toggling  = 1'b0;
        tick(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_acc", 32'(out_acc), 32'd0);
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        tick(1);

        // Single beat and its three-cycle latency
        push_exp(32'h100, 1, 1'b0);
        send_beat(12'h0FF, 12'h001, 1'b1);
        check("lat_t1_valid", 32'(out_valid), 32'd0);
        tick(1);
        check("lat_t2_valid", 32'(out_valid), 32'd0);
        tick(1);
        check("lat_t3_valid", 32'(out_valid), 32'd1);
        wait_drain("single_drain");

        // Back-to-back 4-beat vector followed at once by a 1-beat vector
        push_exp(1010, 4, 1'b0);
        push_exp(10, 1, 1'b0);
        c0 = cyc;
        send_beat(100, 1, 1'b0);
        send_beat(200, 2, 1'b0);
        send_beat(300, 3, 1'b0);
        send_beat(400, 4, 1'b1);
        send_beat(5, 5, 1'b1);
        check("b2b_cycles", 32'(cyc - c0), 32'd5);
        wait_drain("b2b_drain");

        // Backpressure: result A held while vector B is offered
        out_ready = 1'b0;
        push_exp(33, 2, 1'b0);
        push_exp(15, 2, 1'b0);
        send_beat(10, 1, 1'b0);
        send_beat(20, 2, 1'b1);
        k = 0;
        while (!out_valid && k < 20) begin
            tick(1);
            k++;
        end
        check("bp_a_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_sum   = 12'd7;
        in_carry = 12'd0;
        in_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_a_acc_hold", 32'(out_acc), 32'd33);
            check("bp_a_cnt_hold", 32'(out_cnt), 32'd2);
            check("bp_a_valid_hold", 32'(out_valid), 32'd1);
        end
        tick(1);
        out_ready = 1'b1;
        send_beat(7, 0, 1'b0);
        send_beat(8, 0, 1'b1);
        wait_drain("bp_drain");

        // Random out_ready toggling across several vectors
        push_exp(21, 3, 1'b0);
        push_exp(4093, 1, 1'b0);
        push_exp(2000, 4, 1'b0);
        toggling = 1'b1;
        fork
            begin
                while (toggling) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
                out_ready = 1'b1;
            end
            begin
                send_beat(1, 2, 1'b0);
                send_beat(3, 4, 1'b0);
                send_beat(5, 6, 1'b1);
                send_beat(12'h7FF, 12'h7FE, 1'b1);
                for (int i = 0; i < 4; i++) send_beat(250, 250, i == 3);
                tick(40);
                toggling = 1'b0;
            end
        join
        wait_drain("toggle_drain");

        // Overflow: 9 x (0xFFF + 0xFFF) = 73710 exceeds 16 bits
        push_exp(OVF_ACC, 9, 1'b1);
        for (int i = 0; i < 9; i++) send_beat(12'hFFF, 12'hFFF, i == 8);
        wait_drain("ovf_drain");
        push_exp(10, 1, 1'b0);
        send_beat(5, 5, 1'b1);
        wait_drain("ovf_clear_drain");

        // Reset mid-vector with beats in flight and input still offered
        send_beat(50, 50, 1'b0);
        send_beat(50, 50, 1'b0);
        in_valid = 1'b1;
        in_sum   = 12'd50;
        in_carry = 12'd50;
        rst      = 1'b1;
        tick(2);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_acc", 32'(out_acc), 32'd0);
        check("mid_rst_out_ovf", 32'(out_ovf), 32'd0);
        check("mid_rst_out_cnt", 32'(out_cnt), 32'd0);
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        tick(1);
        push_exp(7, 1, 1'b0);
        send_beat(3, 4, 1'b1);
        wait_drain("mid_rst_drain");
        tick(5);
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/csa_cpa_accum.md
Name: csa_cpa_accum

Overview:
- Downstream consumer of the 3:2 CSA compressor stage in the MGEMMV dot-product datapath.
- Takes one redundant (sum, carry) pair per beat and resolves it to binary with a two-stage split carry-propagate adder.
- Accumulates the resolved values over a vector of beats delimited by in_last, then presents one dot-product result per vector on a valid/ready output.

Parameters:
- S_W, 12, width of in_sum (CSA sum output width)
- C_W, 12, width of in_carry (CSA carry output width; carry bit 0 always 0 from the CSA)
- ACC_W, 24, accumulator/result width; must be >= max(S_W,C_W)+1
- CNT_W, 8, width of per-vector beat counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_sum  in  S_W  CSA sum vector, unsigned
- in_carry  in  C_W  CSA carry vector, unsigned, already weight-aligned with in_sum
- in_last  in  1  beat is final element of current vector
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_acc  out  ACC_W  accumulated vector result
- out_cnt  out  CNT_W  beats in vector, saturating at all-ones
- out_ovf  out  1  accumulator carried out of ACC_W at some point during the vector

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_acc=0, out_cnt=0, out_ovf=0, all pipeline valids=0, acc=0, first=1. in_ready is 1 in the cycle after reset.
- Stall: stall = out_valid & ~out_ready; in_ready = ~stall. When stall is high, every pipeline register holds.
- Operand width: P = max(S_W,C_W)+1. Both operands are zero-extended to P. LO = ceil(P/2), HI = P-LO.
- P1, on accept: register lo_sum = sum[LO-1:0]+carry[LO-1:0] (LO bits plus carry-out c1), the high operand halves, and last.
- P2: hi = sum_hi + carry_hi + c1. Register prod = {hi, lo_sum} (P bits) and last.
- P3, accumulate, when p2_valid & ~stall:
  - acc_next = (first ? 0 : acc) + prod, computed at ACC_W+1 bits.
  - The ovf sticky flag is ORed with bit ACC_W of acc_next.
  - cnt increments, saturating.
- On a p2 last beat:
  - out_acc <= acc_next[ACC_W-1:0], out_cnt <= cnt+1 (saturating), out_ovf <= sticky|carry, out_valid <= 1.
  - first <= 1; sticky and cnt are cleared.
  - Otherwise first <= 0.
- Latency: a last beat accepted at cycle t gives out_valid=1 at t+3. Throughput is one beat per clock when there is no backpressure.
- out_valid clears on out_valid & out_ready unless a new result loads in the same cycle. A handshake and a new load in the same cycle must not lose or duplicate a result.
- Result fields are stable while out_valid & ~out_ready.
- Single-beat vector (in_last on the first beat) is legal.
- rst mid-vector discards all partial state and in-flight beats.
- A held output blocks the next vector's beats. Results always complete in order.

Optional Feature:
- Macro: CSA_CPA_SAT_EN.
- Defined: when the accumulator carries out of ACC_W, acc clamps to all-ones and stays clamped for the rest of the vector. out_ovf still reports the overflow.
- Undefined: acc wraps modulo 2^ACC_W; out_ovf reports the overflow.

Decomposition:
- Shared package mgemmv_csa_pkg: default widths (S_W, C_W, ACC_W, CNT_W), constant functions for P, LO and HI, and a struct type for the P1 pipeline payload.
- Sub-module csa_cpa_split2: the two-stage split carry-propagate adder (P1 and P2), with a hold/enable input driven by ~stall.

Test Plan:
- Reset: assert rst 2 cycles mid-traffic -> out_valid=0, out_acc=0, out_ovf=0, in_ready=1 after release.
- Single beat: sum=0x0FF, carry=0x001, last=1 at t -> out_valid at t+3, out_acc=0x000100, out_cnt=1, out_ovf=0.
- 4-beat vector, back to back: sums 100/200/300/400, carries 1/2/3/4 -> out_acc=1010, out_cnt=4. An immediately following 1-beat vector of 5+5 -> out_acc=10.
- Backpressure:
  - Hold out_ready=0 while result A is valid, and offer vector B -> in_ready=0, A fields stable.
  - Release out_ready -> A, then B, in order, no loss.
  - Toggle out_ready randomly -> results are still exact.
- Overflow, ACC_W=16, 9 beats of 0xFFF+0xFFF:
  - Without macro -> out_acc=8174, out_ovf=1.
  - With CSA_CPA_SAT_EN -> out_acc=0xFFFF, out_ovf=1.
- Reset mid-vector: 2 beats of 50+50, rst, then 1 beat 3+4 last -> out_acc=7, out_cnt=1.
